// File: rtl/bumpy_hit_detector.sv
// rtl/bumpy_hit_detector.sv - smiley/brick overlap edge classifier publishing per-frame collision levels
//
// Purpose: watches the VGA pixel stream, counts pixels where the smiley and a
// brick draw at the same time, sorts them into the four edge bands of the
// smiley bounding box and, at every frame boundary, publishes the previous
// frame's result as levels held for the whole next frame.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   startOfFrame  one-cycle pulse per frame
//   pixelX/Y      current scan position (11-bit signed)
//   topLeftX/Y    smiley top-left corner (11-bit signed)
//   smileyDR      smiley drawing request
//   brickDR       brick drawing request
//   EndGame       respawn in progress; starts the grace period
//   collision     any edge (or interior) hit in the last published frame
//   HitEdgeCode   bit0 bottom, bit1 right, bit2 top, bit3 left
//   hitPulse      one-cycle strobe when a result with collision=1 is published
module bumpy_hit_detector #(
  parameter int OBJ_W         = 32,
  parameter int OBJ_H         = 32,
  parameter int EDGE_BAND     = 4,
  parameter int HIT_THRESHOLD = 2,
  parameter int COUNT_BITS    = 8,
  parameter int GRACE_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        smileyDR,
  input  logic        brickDR,
  input  logic        EndGame,
  output logic        collision,
  output logic [3:0]  HitEdgeCode,
  output logic        hitPulse
);

  localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

  localparam logic signed [11:0] W_S  = 12'(OBJ_W);
  localparam logic signed [11:0] H_S  = 12'(OBJ_H);
  localparam logic signed [11:0] B_S  = 12'(EDGE_BAND);
  localparam logic signed [11:0] WB_S = 12'(OBJ_W - EDGE_BAND);
  localparam logic signed [11:0] HB_S = 12'(OBJ_H - EDGE_BAND);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BITS-1:0] TH_C    = COUNT_BITS'(HIT_THRESHOLD);

  typedef enum logic [1:0] {IDLE, ARMED, GRACE} state_e;

  // Stage 1: offsets relative to the smiley box, overlap flag, delayed SOF.
  logic signed [11:0] off_x_d, off_y_d;
  logic signed [11:0] off_x_q, off_y_q;
  logic               ovl_q, sof1_q, sof2_q;

  assign off_x_d = {pixelX[10], pixelX} - {topLeftX[10], topLeftX};
  assign off_y_d = {pixelY[10], pixelY} - {topLeftY[10], topLeftY};

  // Stage 2 state.
  state_e              state_q;
  logic [GW-1:0]       grace_q;
  logic [COUNT_BITS-1:0] cnt_q [4];
  logic [COUNT_BITS-1:0] cnt_d [4];
  logic                int_q, int_d;

  logic       in_box, valid, accept, interior_hit, col_w;
  logic [3:0] edge_hit, hits_w;

  always_comb begin
    in_box = !off_x_q[11] && (off_x_q < W_S) && !off_y_q[11] && (off_y_q < H_S);
    valid  = ovl_q && in_box;

    edge_hit[0] = valid && (off_y_q >= HB_S);
    edge_hit[1] = valid && (off_x_q >= WB_S);
    edge_hit[2] = valid && (off_y_q < B_S);
    edge_hit[3] = valid && (off_x_q < B_S);
    interior_hit = valid && (edge_hit == 4'b0000);

    // Pixels count while armed; on the frame boundary that arms the block
    // (first SOF out of IDLE, last SOF of the grace period) the concurrent
    // pixel already belongs to the new frame.
    accept = (state_q == ARMED) ||
             (sof2_q && ((state_q == IDLE) ||
                         ((state_q == GRACE) && (grace_q <= GW'(1)))));

    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = sof2_q ? '0 : cnt_q[i];
      if (accept && edge_hit[i] && (cnt_d[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_d[i] + 1'b1;
      end
    end
    int_d = (sof2_q ? 1'b0 : int_q) | (accept && interior_hit);

    for (int i = 0; i < 4; i++) begin
      hits_w[i] = (cnt_q[i] >= TH_C);
    end
    col_w = (|hits_w) | int_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_x_q     <= '0;
      off_y_q     <= '0;
      ovl_q       <= 1'b0;
      sof1_q      <= 1'b0;
      sof2_q      <= 1'b0;
      state_q     <= IDLE;
      grace_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      int_q       <= 1'b0;
      collision   <= 1'b0;
      HitEdgeCode <= 4'b0000;
      hitPulse    <= 1'b0;
    end else begin
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      ovl_q    <= smileyDR & brickDR;
      sof1_q   <= startOfFrame;
      sof2_q   <= sof1_q;
      hitPulse <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      int_q    <= int_d;

      // EndGame overrides a coincident frame boundary.
      if (EndGame) begin
        state_q     <= GRACE;
        grace_q     <= GW'(GRACE_FRAMES);
        for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        int_q       <= 1'b0;
        collision   <= 1'b0;
        HitEdgeCode <= 4'b0000;
      end else if (sof2_q) begin
        unique case (state_q)
          IDLE: begin
            state_q     <= ARMED;
            collision   <= 1'b0;
            HitEdgeCode <= 4'b0000;
          end
          ARMED: begin
            HitEdgeCode <= hits_w;
            collision   <= col_w;
            hitPulse    <= col_w & ~hitPulse;
          end
          GRACE: begin
            collision   <= 1'b0;
            HitEdgeCode <= 4'b0000;
            if (grace_q <= GW'(1)) begin
              grace_q <= '0;
              state_q <= ARMED;
            end else begin
              grace_q <= grace_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bumpy_hit_detector.sv
// tb/tb_bumpy_hit_detector.sv - randomized self-checking bench for bumpy_hit_detector
module tb_bumpy_hit_detector;

  localparam int W = 32, H = 32, B = 4, TH = 2, GF = 2, SAT = 255;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, smileyDR, brickDR, EndGame;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        collision, hitPulse;
  logic [3:0]  HitEdgeCode;

  bumpy_hit_detector dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .smileyDR(smileyDR), .brickDR(brickDR), .EndGame(EndGame),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .hitPulse(hitPulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: per-frame pixel tallies, plus how many upcoming frame
  // boundaries must publish zeros (and whose frames are ignored).
  int         m_cnt [4];
  bit         m_int;
  int         m_skip;
  bit         eg_high;
  logic [3:0] exp_code;
  logic       exp_col;
  int         tlx, tly;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_int = 0;
  endfunction

  function automatic void bump(input int i);
    if (m_cnt[i] < SAT) m_cnt[i] = m_cnt[i] + 1;
  endfunction

  function automatic void model_pixel(input int ox, input int oy, input bit ovl);
    bit edge_seen;
    edge_seen = 0;
    if (m_skip > 0 || eg_high || !ovl) return;
    if (ox < 0 || ox >= W || oy < 0 || oy >= H) return;
    if (oy >= H - B) begin bump(0); edge_seen = 1; end
    if (ox >= W - B) begin bump(1); edge_seen = 1; end
    if (oy < B)      begin bump(2); edge_seen = 1; end
    if (ox < B)      begin bump(3); edge_seen = 1; end
    if (!edge_seen) m_int = 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      smileyDR = 1'b0;
      brickDR  = 1'b0;
    end
  endtask

  task automatic drive_pixel(input int ox, input int oy, input bit s, input bit b);
    @(negedge clk);
    topLeftX = 11'(tlx);
    topLeftY = 11'(tly);
    pixelX   = 11'(tlx + ox);
    pixelY   = 11'(tly + oy);
    smileyDR = s;
    brickDR  = b;
    model_pixel(ox, oy, s & b);
  endtask

  task automatic pix(input int ox, input int oy);
    drive_pixel(ox, oy, 1'b1, 1'b1);
  endtask

  task automatic check_steady(input string tag);
    check({tag, "_code"},  HitEdgeCode, exp_code);
    check({tag, "_col"},   collision,   exp_col);
    check({tag, "_pulse"}, hitPulse,    1'b0);
  endtask

  task automatic do_sof(input string tag);
    logic [3:0] old_code;
    logic       old_col;
    old_code = exp_code;
    old_col  = exp_col;
    if (eg_high) begin
      exp_code = 4'b0000; exp_col = 1'b0; m_skip = GF;
    end else if (m_skip > 0) begin
      exp_code = 4'b0000; exp_col = 1'b0; m_skip--;
    end else begin
      for (int i = 0; i < 4; i++) exp_code[i] = (m_cnt[i] >= TH);
      exp_col = (|exp_code) | m_int;
    end
    model_clear();
    @(negedge clk);
    smileyDR = 1'b0; brickDR = 1'b0; startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    check({tag, "_old_code"}, HitEdgeCode, old_code);
    check({tag, "_old_col"},  collision,   old_col);
    check({tag, "_pre_pulse"}, hitPulse,   1'b0);
    @(negedge clk);
    check({tag, "_code"},  HitEdgeCode, exp_code);
    check({tag, "_col"},   collision,   exp_col);
    check({tag, "_pulse"}, hitPulse,    exp_col);
    @(negedge clk);
    check({tag, "_pulse_end"}, hitPulse, 1'b0);
  endtask

  task automatic new_box();
    tlx = int'($urandom_range(950)) - 50;
    tly = int'($urandom_range(950)) - 50;
  endtask

  task automatic rand_frame(input string tag, input int mode, input int npix);
    int ox, oy;
    bit s, b;
    new_box();
    idle(3);
    repeat (npix) begin
      s = 1'b1;
      b = ($urandom_range(3) != 0);
      case (mode)
        1: begin ox = 4 + int'($urandom_range(23));  oy = 28 + int'($urandom_range(3)); end
        2: begin ox = 28 + int'($urandom_range(3));  oy = 4 + int'($urandom_range(23)); end
        3: begin ox = int'($urandom_range(3));       oy = int'($urandom_range(3)); end
        4: begin ox = 4 + int'($urandom_range(23));  oy = 4 + int'($urandom_range(23)); end
        5: begin
          ox = ($urandom_range(1) != 0) ? -1 - int'($urandom_range(9)) : 32 + int'($urandom_range(8));
          oy = int'($urandom_range(31));
        end
        default: begin
          ox = int'($urandom_range(48)) - 8;
          oy = int'($urandom_range(48)) - 8;
          s  = ($urandom_range(1) != 0);
        end
      endcase
      drive_pixel(ox, oy, s, b);
    end
    idle(3);
    check_steady(tag);
  endtask

  task automatic pulse_endgame(input string tag);
    idle(2);
    @(negedge clk);
    EndGame = 1'b1;
    m_skip = GF; model_clear(); exp_code = 4'b0000; exp_col = 1'b0;
    @(negedge clk);
    EndGame = 1'b0;
    check_steady(tag);
    idle(2);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; smileyDR = 1'b0; brickDR = 1'b0; EndGame = 1'b0;
    pixelX = '0; pixelY = '0; topLeftX = '0; topLeftY = '0;
    tlx = 100; tly = 100; eg_high = 0;
    model_clear(); m_skip = 1; exp_code = 4'b0000; exp_col = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_steady("reset");

    // First boundary out of reset publishes zeros even with overlap present.
    tlx = 100; tly = 100;
    idle(2); pix(5, 30); pix(6, 30); idle(2);
    do_sof("first_sof");

    // Bottom band rows across the interior columns.
    tlx = 100; tly = 100;
    idle(3);
    for (int x = 4; x < 28; x++) pix(x, 28 + (x % 4));
    idle(3);
    do_sof("bottom");

    // Single right-edge pixel stays below threshold, two reach it.
    idle(3); pix(31, 10); idle(3);
    do_sof("right_one");
    idle(3); pix(31, 10); pix(31, 11); idle(3);
    do_sof("right_two");

    // 2x2 top-left corner counts towards both edges.
    idle(3); pix(0, 0); pix(1, 0); pix(0, 1); pix(1, 1); idle(3);
    do_sof("corner");

    // Interior only: collision without any edge bit.
    idle(3); pix(16, 16); pix(16, 16); pix(16, 16); idle(3);
    do_sof("interior");

    // Out-of-box overlap is ignored; box edges just outside.
    idle(3); pix(-1, 10); pix(32, 10); pix(10, -1); pix(10, 32); pix(32, 32); idle(3);
    do_sof("outside");

    // Randomized frames across all pixel classes.
    for (int f = 0; f < 12; f++) begin
      rand_frame("rand", int'($urandom_range(5)), int'($urandom_range(20)));
      do_sof("rand_sof");
    end

    // EndGame mid-frame: two ignored frames, then results return.
    new_box(); idle(2);
    for (int x = 4; x < 10; x++) pix(x, 29);
    pulse_endgame("eg_pulse");
    for (int x = 4; x < 10; x++) pix(x, 29);
    do_sof("grace1");
    rand_frame("grace_f1", 1, 8);
    do_sof("grace2");
    rand_frame("grace_f2", 1, 8);
    do_sof("after_grace");

    // EndGame held across a frame boundary: it wins and keeps reloading.
    @(negedge clk);
    EndGame = 1'b1; eg_high = 1;
    m_skip = GF; model_clear(); exp_code = 4'b0000; exp_col = 1'b0;
    idle(3);
    check_steady("eg_hold");
    do_sof("eg_hold_sof");
    idle(2);
    @(negedge clk);
    EndGame = 1'b0; eg_high = 0;
    rand_frame("hold_f0", 2, 10);
    do_sof("hold_g1");
    rand_frame("hold_f1", 2, 10);
    do_sof("hold_g2");
    rand_frame("hold_f2", 2, 10);
    do_sof("hold_res");

    // Saturation: 257 bottom pixels must not wrap below threshold.
    new_box(); idle(3);
    for (int k = 0; k < 257; k++) pix(4 + (k % 24), 31);
    idle(3);
    do_sof("saturate");

    // Reset mid-frame discards accumulation and returns to the idle behaviour.
    new_box(); idle(2);
    for (int x = 4; x < 12; x++) pix(x, 30);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    m_skip = 1; model_clear(); exp_code = 4'b0000; exp_col = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_steady("mid_reset");
    for (int x = 4; x < 12; x++) pix(x, 30);
    idle(3);
    do_sof("post_reset_sof");
    rand_frame("post_reset_f", 3, 12);
    do_sof("post_reset_res");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
